// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite slave SRAM; AHB_SLV_WAIT_EN inserts WAIT_CYCLES wait states per transfer
module ahb_slave_mem #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int WA_W  = ADDR_W - 2;
    localparam int DEPTH = 1 << WA_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic              hreadyout_q;
    logic              hresp_q;
    logic [31:0]       hrdata_q;
    logic [31:0]       mem_q [DEPTH];

`ifdef AHB_SLV_WAIT_EN
    localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam bit               HAS_WAIT = (WAIT_CYCLES > 0);
    logic [CNT_W-1:0] cnt_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{HBURST, HTRANS[0]};

    logic accept, misaligned, out_of_range, legal;
    assign accept       = HSEL && HREADY && HTRANS[1];
    assign misaligned   = ((HSIZE == 3'd1) && HADDR[0]) ||
                          ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign out_of_range = |HADDR[31:ADDR_W];
    assign legal        = (HSIZE <= 3'd2) && !misaligned && !out_of_range;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    lane_mask = 4'b0001 << a;
            3'd1:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    logic [3:0]      wr_strb;
    logic [WA_W-1:0] wr_idx;
    logic [WA_W-1:0] rd_idx;
    logic            wr_active;
    logic [31:0]     wr_merged;
    logic [31:0]     rd_word;

    assign wr_strb   = lane_mask(size_q, addr_q[1:0]);
    assign wr_idx    = addr_q[ADDR_W-1:2];
    assign rd_idx    = HADDR[ADDR_W-1:2];
    assign wr_active = (state_q == ST_DATA) && write_q;

    always_comb begin
        wr_merged = mem_q[wr_idx];
        for (int i = 0; i < 4; i++) begin
            if (wr_strb[i]) begin
                wr_merged[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    // A read accepted while a write to the same word finishes takes the merged word directly.
    assign rd_word = (wr_active && (wr_idx == rd_idx)) ? wr_merged : mem_q[rd_idx];

    always_ff @(posedge HCLK) begin
        if (wr_active) begin
            mem_q[wr_idx] <= wr_merged;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
`ifdef AHB_SLV_WAIT_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DATA: begin
                    if (accept) begin
                        addr_q  <= HADDR[ADDR_W-1:0];
                        write_q <= HWRITE;
                        size_q  <= HSIZE;
                        if (!legal) begin
                            state_q     <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b1;
                        end else begin
                            hresp_q <= 1'b0;
                            if (!HWRITE) begin
                                hrdata_q <= rd_word;
                            end
`ifdef AHB_SLV_WAIT_EN
                            if (HAS_WAIT) begin
                                state_q     <= ST_WAIT;
                                hreadyout_q <= 1'b0;
                                cnt_q       <= CNT_LOAD;
                            end else begin
                                state_q     <= ST_DATA;
                                hreadyout_q <= 1'b1;
                            end
`else
                            state_q     <= ST_DATA;
                            hreadyout_q <= 1'b1;
`endif
                        end
                    end else begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
`ifdef AHB_SLV_WAIT_EN
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= ST_DATA;
                        hreadyout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
`endif
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                // ERR2 drops any address phase seen alongside it
                default: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
            endcase
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
endmodule
